// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg : state and owner types shared by mem_port_arbiter and rr_pick2
// Revision    : 1.0
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, CMD, RESP} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if : fetch port, data port and memory-side bus
// Revision            : 1.0
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ready;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  // Arbiter view
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rvalid, m_rdata,
    output i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
           m_req, m_we, m_addr, m_wdata
  );

  // Core and memory view
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rvalid, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
           m_req, m_we, m_addr, m_wdata
  );

endinterface
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// rr_pick2 : two-way winner select, round-robin or data-priority with starvation override
// Revision : 1.0
// ============================================================================
module rr_pick2
  import mem_arb_pkg::*;
(
  input  wire logic       i_fetch_req,
  input  wire logic       i_data_req,
  input  wire arb_owner_t i_last,
  input  wire logic       i_fixed,
  input  wire logic       i_starved,
  output arb_owner_t      o_win
);

  always_comb begin
    o_win = OWN_I;
    if (i_data_req && !i_fetch_req) begin
      o_win = OWN_D;
    end else if (i_data_req && i_fetch_req) begin
      if (i_fixed) begin
        o_win = i_starved ? OWN_I : OWN_D;
      end else begin
        o_win = (i_last == OWN_D) ? OWN_I : OWN_D;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one memory between fetch and data ports, one transaction in flight
// Revision         : 1.0
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input wire logic          clk,
  input wire logic          reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam int              TW           = $clog2(TIMEOUT);
  localparam int              SW           = $clog2(STARVE_MAX + 1);
  localparam logic [TW-1:0]   C_TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0]   C_STARVE_MAX = SW'(STARVE_MAX);

  arb_state_t        r_state;
  arb_state_t        w_next;
  arb_owner_t        r_owner;
  arb_owner_t        r_last;
  arb_owner_t        w_win;
  logic [SW-1:0]     r_starve;
  logic [TW-1:0]     r_tmo;
  logic              r_cmd_we;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [DATA_W-1:0] r_cmd_wdata;
  logic              w_any;
  logic              w_grant;
  logic              w_tmo_hit;
  logic              w_done;
  logic [DATA_W-1:0] w_rsp_data;

  assign w_any     = bus.i_req | bus.d_req;
  assign w_grant   = (r_state == IDLE) && w_any;
  assign w_tmo_hit = (r_state == RESP) && (r_tmo == C_TMO_LAST);
  assign w_done    = (r_state == RESP) && (bus.m_rvalid || w_tmo_hit);

  rr_pick2 u_pick (
    .i_fetch_req (bus.i_req),
    .i_data_req  (bus.d_req),
    .i_last      (r_last),
    .i_fixed     (FIXED_PRIO != 0),
    .i_starved   (r_starve == C_STARVE_MAX),
    .o_win       (w_win)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any)              w_next = CMD;
      CMD:     if (bus.m_ready)        w_next = RESP;
      RESP:    if (w_done)             w_next = IDLE;
      default:                         w_next = IDLE;
    endcase
  end

  // Grants are combinational, so they need explicit gating while reset is held
  always_comb begin
    bus.i_gnt    = 1'b0;
    bus.d_gnt    = 1'b0;
    bus.i_rvalid = 1'b0;
    bus.i_err    = 1'b0;
    bus.i_rdata  = '0;
    bus.d_rvalid = 1'b0;
    bus.d_err    = 1'b0;
    bus.d_rdata  = '0;
    bus.m_req    = 1'b0;
    bus.m_we     = 1'b0;
    bus.m_addr   = '0;
    bus.m_wdata  = '0;
    w_rsp_data   = (bus.m_rvalid && !r_cmd_we) ? bus.m_rdata : '0;
    case (r_state)
      IDLE: begin
        if (reset_n && w_any) begin
          bus.i_gnt = (w_win == OWN_I);
          bus.d_gnt = (w_win == OWN_D);
        end
      end
      CMD: begin
        bus.m_req   = 1'b1;
        bus.m_we    = r_cmd_we;
        bus.m_addr  = r_cmd_addr;
        bus.m_wdata = r_cmd_wdata;
      end
      RESP: begin
        if (w_done && (r_owner == OWN_I)) begin
          bus.i_rvalid = 1'b1;
          bus.i_err    = !bus.m_rvalid;
          bus.i_rdata  = w_rsp_data;
        end
        if (w_done && (r_owner == OWN_D)) begin
          bus.d_rvalid = 1'b1;
          bus.d_err    = !bus.m_rvalid;
          bus.d_rdata  = w_rsp_data;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner     <= OWN_I;
      r_last      <= OWN_D;
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
    end else if (w_grant) begin
      r_owner     <= w_win;
      r_last      <= w_win;
      r_cmd_we    <= (w_win == OWN_D) && bus.d_we;
      r_cmd_addr  <= (w_win == OWN_D) ? bus.d_addr : bus.i_addr;
      r_cmd_wdata <= (w_win == OWN_D) ? bus.d_wdata : '0;
    end
  end

  // Counts data grants taken while fetch was also waiting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve <= '0;
    end else if (w_grant) begin
      if (w_win == OWN_I) begin
        r_starve <= '0;
      end else if (bus.i_req && (r_starve != C_STARVE_MAX)) begin
        r_starve <= r_starve + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo <= '0;
    end else if ((r_state == CMD) && bus.m_ready) begin
      r_tmo <= '0;
    end else if (r_state == RESP) begin
      r_tmo <= r_tmo + TW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// tb_mem_port_arbiter : two arbiters (round-robin / fixed priority) against a transaction-level model,
// with directed scenarios pinned by literal expectations followed by randomized traffic.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        i_gnt;
    logic        d_gnt;
    logic        i_rv;
    logic        i_err;
    logic        d_rv;
    logic        d_err;
    logic        m_req;
    logic        m_we;
    logic [31:0] i_rd;
    logic [31:0] d_rd;
    logic [31:0] m_addr;
    logic [31:0] m_wd;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        tb_i_req[2];
  logic [31:0] tb_i_addr[2];
  logic        tb_d_req[2];
  logic        tb_d_we[2];
  logic [31:0] tb_d_addr[2];
  logic [31:0] tb_d_wdata[2];
  logic        tb_m_ready[2];
  logic        tb_m_rvalid[2];
  logic [31:0] tb_m_rdata[2];
  obs_t        dut_o[2];

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .STARVE_MAX(4), .TIMEOUT(64)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .STARVE_MAX(4), .TIMEOUT(8)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave));

  assign bus0.i_req = tb_i_req[0];     assign bus1.i_req = tb_i_req[1];
  assign bus0.i_addr = tb_i_addr[0];   assign bus1.i_addr = tb_i_addr[1];
  assign bus0.d_req = tb_d_req[0];     assign bus1.d_req = tb_d_req[1];
  assign bus0.d_we = tb_d_we[0];       assign bus1.d_we = tb_d_we[1];
  assign bus0.d_addr = tb_d_addr[0];   assign bus1.d_addr = tb_d_addr[1];
  assign bus0.d_wdata = tb_d_wdata[0]; assign bus1.d_wdata = tb_d_wdata[1];
  assign bus0.m_ready = tb_m_ready[0]; assign bus1.m_ready = tb_m_ready[1];
  assign bus0.m_rvalid = tb_m_rvalid[0]; assign bus1.m_rvalid = tb_m_rvalid[1];
  assign bus0.m_rdata = tb_m_rdata[0]; assign bus1.m_rdata = tb_m_rdata[1];

  assign dut_o[0] = {bus0.i_gnt, bus0.d_gnt, bus0.i_rvalid, bus0.i_err, bus0.d_rvalid, bus0.d_err,
                     bus0.m_req, bus0.m_we, bus0.i_rdata, bus0.d_rdata, bus0.m_addr, bus0.m_wdata};
  assign dut_o[1] = {bus1.i_gnt, bus1.d_gnt, bus1.i_rvalid, bus1.i_err, bus1.d_rvalid, bus1.d_err,
                     bus1.m_req, bus1.m_we, bus1.i_rdata, bus1.d_rdata, bus1.m_addr, bus1.m_wdata};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One pending transaction per arbiter: who owns it, its command, whether memory took it,
  // and how many response cycles have passed without data.
  bit          mb_busy[2];
  bit          mb_acc[2];
  bit          mb_own[2];   // 1 = data port
  bit          mb_we[2];
  logic [31:0] mb_addr[2];
  logic [31:0] mb_wd[2];
  int          mb_wait[2];
  bit          mb_lastd[2];
  int          mb_streak[2];
  bit          mb_gi[2];
  bit          mb_gd[2];

  function automatic int timeout_of(int k);
    return (k == 0) ? 64 : 8;
  endfunction

  function automatic bit data_wins(int k);
    if (!tb_i_req[k]) return 1'b1;
    if (!tb_d_req[k]) return 1'b0;
    if (k == 1) return mb_streak[k] != 4;
    return !mb_lastd[k];
  endfunction

  function automatic obs_t expect_out(int k);
    obs_t        e;
    logic [31:0] rd;
    bit          rsp;
    e = '0;
    if (!reset_n) return e;
    if (!mb_busy[k]) begin
      if (tb_i_req[k] || tb_d_req[k]) begin
        e.d_gnt = data_wins(k);
        e.i_gnt = !e.d_gnt;
      end
    end else if (!mb_acc[k]) begin
      e.m_req  = 1'b1;
      e.m_we   = mb_we[k];
      e.m_addr = mb_addr[k];
      e.m_wd   = mb_wd[k];
    end else begin
      rsp = tb_m_rvalid[k] || (mb_wait[k] + 1 == timeout_of(k));
      rd  = (tb_m_rvalid[k] && !mb_we[k]) ? tb_m_rdata[k] : 32'h0;
      if (rsp && mb_own[k]) begin
        e.d_rv = 1'b1; e.d_err = !tb_m_rvalid[k]; e.d_rd = rd;
      end
      if (rsp && !mb_own[k]) begin
        e.i_rv = 1'b1; e.i_err = !tb_m_rvalid[k]; e.i_rd = rd;
      end
    end
    return e;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        mb_busy[k] <= 1'b0; mb_acc[k] <= 1'b0; mb_lastd[k] <= 1'b1;
        mb_streak[k] <= 0;  mb_gi[k] <= 1'b0;  mb_gd[k] <= 1'b0; mb_wait[k] <= 0;
      end else begin
        mb_gi[k] <= 1'b0;
        mb_gd[k] <= 1'b0;
        if (!mb_busy[k]) begin
          if (tb_i_req[k] || tb_d_req[k]) begin
            mb_busy[k]  <= 1'b1;
            mb_acc[k]   <= 1'b0;
            mb_own[k]   <= data_wins(k);
            mb_lastd[k] <= data_wins(k);
            mb_we[k]    <= data_wins(k) && tb_d_we[k];
            mb_addr[k]  <= data_wins(k) ? tb_d_addr[k] : tb_i_addr[k];
            mb_wd[k]    <= data_wins(k) ? tb_d_wdata[k] : 32'h0;
            mb_gd[k]    <= data_wins(k);
            mb_gi[k]    <= !data_wins(k);
            if (!data_wins(k)) mb_streak[k] <= 0;
            else if (tb_i_req[k] && mb_streak[k] < 4) mb_streak[k] <= mb_streak[k] + 1;
          end
        end else if (!mb_acc[k]) begin
          if (tb_m_ready[k]) begin
            mb_acc[k]  <= 1'b1;
            mb_wait[k] <= 0;
          end
        end else if (tb_m_rvalid[k] || (mb_wait[k] + 1 == timeout_of(k))) begin
          mb_busy[k] <= 1'b0;
        end else begin
          mb_wait[k] <= mb_wait[k] + 1;
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      obs_t e;
      obs_t a;
      bit   ci, cd, cm;
      e  = expect_out(k);
      a  = dut_o[k];
      ci = !reset_n || e.i_rv || (mb_busy[k] && mb_own[k]);
      cd = !reset_n || e.d_rv || (mb_busy[k] && !mb_own[k]);
      cm = !reset_n || e.m_req;
      chk($sformatf("u%0d.i_gnt", k), a.i_gnt, e.i_gnt);
      chk($sformatf("u%0d.d_gnt", k), a.d_gnt, e.d_gnt);
      chk($sformatf("u%0d.i_rvalid", k), a.i_rv, e.i_rv);
      chk($sformatf("u%0d.d_rvalid", k), a.d_rv, e.d_rv);
      chk($sformatf("u%0d.m_req", k), a.m_req, e.m_req);
      if (ci) begin
        chk($sformatf("u%0d.i_err", k), a.i_err, e.i_err);
        chk($sformatf("u%0d.i_rdata", k), a.i_rd, e.i_rd);
      end
      if (cd) begin
        chk($sformatf("u%0d.d_err", k), a.d_err, e.d_err);
        chk($sformatf("u%0d.d_rdata", k), a.d_rd, e.d_rd);
      end
      if (cm) begin
        chk($sformatf("u%0d.m_we", k), a.m_we, e.m_we);
        chk($sformatf("u%0d.m_addr", k), a.m_addr, e.m_addr);
        chk($sformatf("u%0d.m_wdata", k), a.m_wd, e.m_wd);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in(input int k);
    tb_i_req[k] = 1'b0; tb_i_addr[k] = '0; tb_d_req[k] = 1'b0; tb_d_we[k] = 1'b0;
    tb_d_addr[k] = '0;  tb_d_wdata[k] = '0; tb_m_ready[k] = 1'b0; tb_m_rvalid[k] = 1'b0;
    tb_m_rdata[k] = '0;
  endtask

  task automatic drain(input int k);
    tb_i_req[k] = 1'b0; tb_d_req[k] = 1'b0; tb_m_ready[k] = 1'b1; tb_m_rvalid[k] = 1'b1;
    repeat (5) tick();
    idle_in(k);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    byte   gseq[10];
    string exp_rr;
    string exp_fx;
    int    n;
    bit    found;
    obs_t  m;

    reset_n = 1'b0;
    idle_in(0);
    idle_in(1);
    tb_i_req[0] = 1'b1; tb_d_req[0] = 1'b1;
    @(negedge clk);
    chk("rst_i_gnt", bus0.i_gnt, 1'b0);
    chk("rst_d_gnt", bus0.d_gnt, 1'b0);
    chk("rst_m_req", bus0.m_req, 1'b0);
    tick();
    idle_in(0);
    reset_n = 1'b1;
    tick();

    // single fetch
    tb_i_req[0] = 1'b1; tb_i_addr[0] = 32'h100;
    @(negedge clk);
    m = expect_out(0);
    chk("sf_model_i_gnt", m.i_gnt, 1'b1);
    chk("sf_i_gnt", bus0.i_gnt, 1'b1);
    chk("sf_d_gnt", bus0.d_gnt, 1'b0);
    tick();
    tb_i_req[0] = 1'b0; tb_m_ready[0] = 1'b1;
    @(negedge clk);
    chk("sf_m_req", bus0.m_req, 1'b1);
    chk("sf_m_addr", bus0.m_addr, 32'h100);
    chk("sf_m_we", bus0.m_we, 1'b0);
    tick();
    tb_m_ready[0] = 1'b0;
    @(negedge clk);
    chk("sf_early_rvalid", bus0.i_rvalid, 1'b0);
    tick();
    tb_m_rvalid[0] = 1'b1; tb_m_rdata[0] = 32'hE3A01005;
    @(negedge clk);
    chk("sf_i_rvalid", bus0.i_rvalid, 1'b1);
    chk("sf_i_rdata", bus0.i_rdata, 32'hE3A01005);
    chk("sf_i_err", bus0.i_err, 1'b0);
    chk("sf_d_rvalid", bus0.d_rvalid, 1'b0);
    chk("sf_d_rdata", bus0.d_rdata, 32'h0);
    tick();
    tb_m_rvalid[0] = 1'b0;

    // data write with three stall cycles
    tb_d_req[0] = 1'b1; tb_d_we[0] = 1'b1; tb_d_addr[0] = 32'h200; tb_d_wdata[0] = 32'hDEADBEEF;
    @(negedge clk);
    chk("dw_d_gnt", bus0.d_gnt, 1'b1);
    tick();
    tb_d_req[0] = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("dw_stall_m_req", bus0.m_req, 1'b1);
      chk("dw_stall_m_addr", bus0.m_addr, 32'h200);
      chk("dw_stall_m_wdata", bus0.m_wdata, 32'hDEADBEEF);
      chk("dw_stall_m_we", bus0.m_we, 1'b1);
      tick();
    end
    tb_m_ready[0] = 1'b1;
    tick();
    tb_m_ready[0] = 1'b0; tb_m_rvalid[0] = 1'b1; tb_m_rdata[0] = 32'h12345678;
    @(negedge clk);
    chk("dw_d_rvalid", bus0.d_rvalid, 1'b1);
    chk("dw_d_rdata", bus0.d_rdata, 32'h0);
    chk("dw_d_err", bus0.d_err, 1'b0);
    chk("dw_i_rvalid", bus0.i_rvalid, 1'b0);
    tick();
    tb_m_rvalid[0] = 1'b0;

    // round-robin with both ports requesting continuously
    exp_rr = "IDIDID";
    foreach (gseq[j]) gseq[j] = "-";
    tb_i_req[0] = 1'b1; tb_d_req[0] = 1'b1; tb_d_we[0] = 1'b0;
    tb_m_ready[0] = 1'b1; tb_m_rvalid[0] = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge clk);
      if (bus0.i_gnt) begin gseq[n] = "I"; n++; end
      else if (bus0.d_gnt) begin gseq[n] = "D"; n++; end
      tick();
    end
    for (int j = 0; j < 6; j++) chk($sformatf("rr_grant%0d", j), gseq[j], exp_rr[j]);
    drain(0);

    // fixed priority with starvation limit
    exp_fx = "DDDDIDDDDI";
    foreach (gseq[j]) gseq[j] = "-";
    tb_i_req[1] = 1'b1; tb_d_req[1] = 1'b1;
    tb_m_ready[1] = 1'b1; tb_m_rvalid[1] = 1'b1;
    n = 0;
    for (int c = 0; c < 80 && n < 10; c++) begin
      @(negedge clk);
      if (bus1.i_gnt) begin gseq[n] = "I"; n++; end
      else if (bus1.d_gnt) begin gseq[n] = "D"; n++; end
      tick();
    end
    for (int j = 0; j < 10; j++) chk($sformatf("fx_grant%0d", j), gseq[j], exp_fx[j]);
    drain(1);

    // response timeout
    tb_i_req[0] = 1'b1; tb_i_addr[0] = 32'h300;
    @(negedge clk);
    tick();
    tb_i_req[0] = 1'b0; tb_m_ready[0] = 1'b1;
    @(negedge clk);
    tick();
    tb_m_ready[0] = 1'b0;
    n = 0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      n++;
      if (bus0.i_rvalid) begin
        found = 1'b1;
        chk("to_i_err", bus0.i_err, 1'b1);
        chk("to_i_rdata", bus0.i_rdata, 32'h0);
      end else begin
        tick();
      end
    end
    chk("to_resp_cycles", n, 64);
    tick();
    tb_i_req[0] = 1'b1; tb_i_addr[0] = 32'h400;
    @(negedge clk);
    chk("to_next_gnt", bus0.i_gnt, 1'b1);
    tick();
    drain(0);

    // asynchronous reset while waiting for a response
    tb_d_req[0] = 1'b1; tb_d_we[0] = 1'b0; tb_d_addr[0] = 32'h500;
    @(negedge clk);
    tick();
    tb_d_req[0] = 1'b0; tb_m_ready[0] = 1'b1;
    @(negedge clk);
    tick();
    tb_m_ready[0] = 1'b0;
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    tb_i_req[0] = 1'b1; tb_d_req[0] = 1'b1;
    #1;
    chk("mr_rst_i_gnt", bus0.i_gnt, 1'b0);
    chk("mr_rst_d_gnt", bus0.d_gnt, 1'b0);
    chk("mr_rst_d_rvalid", bus0.d_rvalid, 1'b0);
    tick();
    tb_i_req[0] = 1'b0; tb_d_req[0] = 1'b0;
    reset_n = 1'b1;
    tb_m_rvalid[0] = 1'b1; tb_m_rdata[0] = 32'hCAFE0001;
    @(negedge clk);
    chk("mr_late_i_rvalid", bus0.i_rvalid, 1'b0);
    chk("mr_late_d_rvalid", bus0.d_rvalid, 1'b0);
    tick();
    tb_m_rvalid[0] = 1'b0;
    tb_i_req[0] = 1'b1; tb_d_req[0] = 1'b1;
    tb_i_req[1] = 1'b1; tb_d_req[1] = 1'b1;
    @(negedge clk);
    chk("mr_rr_first_i_gnt", bus0.i_gnt, 1'b1);
    chk("mr_fx_first_d_gnt", bus1.d_gnt, 1'b1);
    tick();
    drain(0);
    drain(1);

    // randomized traffic on both arbiters
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) reset_n = 1'b0;
      if (c == 2003) reset_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
        if (!tb_i_req[k] || mb_gi[k]) begin
          tb_i_req[k]  = ($urandom_range(0, 99) < 45);
          tb_i_addr[k] = $urandom;
        end
        if (!tb_d_req[k] || mb_gd[k]) begin
          tb_d_req[k]   = ($urandom_range(0, 99) < 55);
          tb_d_we[k]    = $urandom_range(0, 1) == 1;
          tb_d_addr[k]  = $urandom;
          tb_d_wdata[k] = $urandom;
        end
        tb_m_ready[k]  = $urandom_range(0, 99) < 50;
        tb_m_rvalid[k] = $urandom_range(0, 99) < 25;
        tb_m_rdata[k]  = $urandom;
      end
      tick();
    end
    drain(0);
    drain(1);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the ARM core's instruction-fetch port and data port. One transaction is outstanding at a time.
- Picks a winner, latches its command and drives the memory-side address/data select. It then routes the response back to the owner and flags any response timeout.
- Sits between the core (fetch and load/store units) and the unified memory model. It replaces the free-running address multiplexer select with a sequenced one.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- FIXED_PRIO, 0, 0 = round-robin; 1 = data port has fixed priority, subject to the starvation limit.
- STARVE_MAX, 4, consecutive data grants allowed while fetch is waiting before fetch is forced (FIXED_PRIO=1 only). Must be ≥1.
- TIMEOUT, 64, cycles in RESP with no m_rvalid before an error response is returned. Must be ≥2.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; held until i_gnt.
- i_addr  in  ADDR_W  fetch address.
- i_gnt  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  fetch response valid (1-cycle pulse).
- i_rdata  out  DATA_W  fetch read data.
- i_err  out  1  fetch response is a timeout error; qualified by i_rvalid.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  data write enable.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  data write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data response valid (1-cycle pulse); also returned for writes.
- d_rdata  out  DATA_W  data read data (0 for writes).
- d_err  out  1  data response is a timeout error.
- m_req  out  1  memory command valid.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_ready  in  1  memory accepts command this cycle.
- m_rvalid  in  1  memory response valid.
- m_rdata  in  DATA_W  memory read data.

Behaviour:
- FSM states: IDLE, CMD, RESP. Reset puts the FSM in IDLE.
- Reset clears: the owner register, the last-grant register (last = DATA, so fetch wins the first tie), the starvation counter and the timeout counter. All outputs are 0 while reset_n = 0.
- Reset is asynchronous and may occur mid-transaction. It aborts the transaction with no response, and any late m_rvalid after reset is ignored while the FSM is in IDLE.

IDLE:
- If either request is high, the block selects a winner and asserts that port's gnt combinationally in the same cycle.
- On the clock edge it latches addr/we/wdata into command registers (fetch: we = 0, wdata = 0), sets owner and goes to CMD.
- With no request it stays in IDLE and both gnt are 0. The gnt signals are never asserted outside IDLE.

Arbitration with both requesting:
- Round-robin: the port not granted last wins.
- FIXED_PRIO=1: data wins unless the starvation counter equals STARVE_MAX, in which case fetch wins.
- Starvation counter: increments on each data grant while i_req is high, clears on any fetch grant, and saturates at STARVE_MAX.
- With a single requester, that requester wins in both modes.

CMD:
- m_req = 1 and m_we/m_addr/m_wdata come from the command registers; they are stable while m_req is high.
- On m_ready the FSM goes to RESP and the timeout counter clears.

RESP:
- m_req = 0. The timeout counter increments each cycle.
- When m_rvalid is high, m_rdata is passed combinationally to the owner's rdata (forced to 0 for a write). The owner's rvalid pulses with err = 0 and the FSM goes to IDLE.
- When the counter reaches TIMEOUT-1 with no m_rvalid, the owner's rvalid pulses with err = 1 and rdata = 0, and the FSM goes to IDLE.

Other rules:
- m_rvalid outside RESP is ignored.
- The non-owner port's rvalid, err and rdata are 0.
- Minimum transaction is 3 cycles (grant, CMD with m_ready, RESP with m_rvalid). A new grant is possible in the cycle after a response.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, CMD, RESP} arb_state_t;
  - typedef enum logic {OWN_I, OWN_D} arb_owner_t;
- One sub-module, rr_pick2: a 2-way round-robin/priority picker taking both requests, the last grant, the mode and the starvation flag, and producing the winner.
- Counters and FSM stay in the top level.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100; memory gives m_ready in CMD and m_rvalid with m_rdata=0xE3A01005 two cycles later → i_gnt in cycle 0, m_addr=0x100 with m_we=0, one i_rvalid pulse with i_rdata=0xE3A01005 and i_err=0, and d_* outputs stay 0.
- Data write: d_req=1, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF; m_ready held low 3 cycles → m_req/m_addr/m_wdata stable across all stall cycles, then the d_rvalid pulse has d_rdata=0.
- Round-robin: i_req and d_req held high continuously for 6 transactions → grants alternate I, D, I, D, I, D.
- FIXED_PRIO=1, STARVE_MAX=4: both requesting continuously → grants D, D, D, D, I, D, D, D, D, I.
- Timeout with TIMEOUT=64: memory never asserts m_rvalid after m_ready → owner's rvalid with err=1 and rdata=0 exactly 64 cycles after entering RESP; the next request is granted the following cycle.
- Reset mid-RESP: reset_n pulsed low, then m_rvalid asserted after release → no rvalid on either port, all outputs 0 during reset, and the fetch wins the first contested grant after release.
